// File: rtl/interval_timer_ctrl.sv
// Interval-training sequencer: PREP -> WORK/REST rounds -> DONE, paced by the
// divided 1 Hz clock, with a phase-change beep gate on the 2 kHz tone.
`timescale 1ns/1ps
module interval_timer_ctrl #(
  parameter int PREP_S = 5,
  parameter int WORK_S = 30,
  parameter int REST_S = 10,
  parameter int ROUNDS = 8,
  parameter int BEEP_S = 1,
  parameter int CNT_W  = 7
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             clk_1Hz,
  input  logic             clk_2kHz,
  input  logic             start,
  input  logic             pause_tgl,
  input  logic             stop,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] secs,
  output logic [3:0]       round,
  output logic             paused,
  output logic             done,
  output logic             buzzer
);

  localparam int BEEP_MAX = 3 * BEEP_S;
  localparam int BEEP_W   = (BEEP_MAX < 1) ? 1 : $clog2(BEEP_MAX + 1);

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_PREP = 3'd1,
    PH_WORK = 3'd2,
    PH_REST = 3'd3,
    PH_DONE = 3'd4
  } phase_e;

  logic              sync1_q, sync2_q, edge_q, tick_q;
  phase_e            phase_q, phase_d;
  logic [CNT_W-1:0]  secs_q, secs_d;
  logic [3:0]        round_q, round_d;
  logic              paused_q, paused_d;
  logic              done_q, done_d;
  logic [BEEP_W-1:0] beep_q, beep_d;
  logic              buzzer_q, buzzer_d;
  logic              counting;

  always_comb begin
    phase_d  = phase_q;
    secs_d   = secs_q;
    round_d  = round_q;
    paused_d = paused_q;
    done_d   = done_q;
    beep_d   = beep_q;
    buzzer_d = clk_2kHz & (beep_q != '0);
    counting = (phase_q == PH_PREP) || (phase_q == PH_WORK) || (phase_q == PH_REST);

    // The beep runs down on every tick, even while paused; loads below override it.
    if (tick_q && (beep_q != '0))
      beep_d = beep_q - 1'b1;

    if (stop) begin
      phase_d  = PH_IDLE;
      secs_d   = '0;
      round_d  = '0;
      paused_d = 1'b0;
      done_d   = 1'b0;
      beep_d   = '0;
      buzzer_d = 1'b0;
    end else if (start && !counting) begin
      if (PREP_S == 0) begin
        phase_d = PH_WORK;
        secs_d  = CNT_W'(WORK_S);
      end else begin
        phase_d = PH_PREP;
        secs_d  = CNT_W'(PREP_S);
      end
      round_d  = 4'd1;
      paused_d = 1'b0;
      done_d   = 1'b0;
      beep_d   = BEEP_W'(BEEP_S);
    end else if (pause_tgl && counting) begin
      paused_d = ~paused_q;
    end else if (tick_q && counting && !paused_q) begin
      if (secs_q > CNT_W'(1)) begin
        secs_d = secs_q - CNT_W'(1);
      end else begin
        beep_d = BEEP_W'(BEEP_S);
        case (phase_q)
          PH_PREP: begin
            phase_d = PH_WORK;
            secs_d  = CNT_W'(WORK_S);
          end
          PH_REST: begin
            phase_d = PH_WORK;
            secs_d  = CNT_W'(WORK_S);
            round_d = round_q + 4'd1;
          end
          default: begin
            if (round_q < 4'(ROUNDS)) begin
              phase_d = PH_REST;
              secs_d  = CNT_W'(REST_S);
            end else begin
              phase_d = PH_DONE;
              secs_d  = '0;
              done_d  = 1'b1;
              beep_d  = BEEP_W'(BEEP_MAX);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      edge_q   <= 1'b0;
      tick_q   <= 1'b0;
      phase_q  <= PH_IDLE;
      secs_q   <= '0;
      round_q  <= '0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
      beep_q   <= '0;
      buzzer_q <= 1'b0;
    end else begin
      sync1_q  <= clk_1Hz;
      sync2_q  <= sync1_q;
      edge_q   <= sync2_q;
      tick_q   <= sync2_q & ~edge_q;
      phase_q  <= phase_d;
      secs_q   <= secs_d;
      round_q  <= round_d;
      paused_q <= paused_d;
      done_q   <= done_d;
      beep_q   <= beep_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign phase  = phase_q;
  assign secs   = secs_q;
  assign round  = round_q;
  assign paused = paused_q;
  assign done   = done_q;
  assign buzzer = buzzer_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Bench for interval_timer_ctrl: two instances (PREP_S=1 and PREP_S=0) compared
// every cycle against a session-schedule model, plus a directed vector table.
`timescale 1ns/1ps
module tb_interval_timer_ctrl;
  localparam int CW       = 7;
  localparam int M_WORK   = 3;
  localparam int M_REST   = 2;
  localparam int M_ROUNDS = 2;
  localparam int M_BEEP   = 1;

  logic clk_in = 1'b0, reset_n = 1'b0, clk_1Hz = 1'b0, clk_2kHz = 1'b0;
  logic start = 1'b0, pause_tgl = 1'b0, stop = 1'b0;
  logic [2:0] phase_a, phase_b;
  logic [CW-1:0] secs_a, secs_b;
  logic [3:0] round_a, round_b;
  logic paused_a, paused_b, done_a, done_b, buzzer_a, buzzer_b;

  interval_timer_ctrl #(.PREP_S(1), .WORK_S(M_WORK), .REST_S(M_REST), .ROUNDS(M_ROUNDS),
                        .BEEP_S(M_BEEP), .CNT_W(CW)) dut_a (
    .clk_in(clk_in), .reset_n(reset_n), .clk_1Hz(clk_1Hz), .clk_2kHz(clk_2kHz),
    .start(start), .pause_tgl(pause_tgl), .stop(stop), .phase(phase_a), .secs(secs_a),
    .round(round_a), .paused(paused_a), .done(done_a), .buzzer(buzzer_a));

  interval_timer_ctrl #(.PREP_S(0), .WORK_S(M_WORK), .REST_S(M_REST), .ROUNDS(M_ROUNDS),
                        .BEEP_S(M_BEEP), .CNT_W(CW)) dut_b (
    .clk_in(clk_in), .reset_n(reset_n), .clk_1Hz(clk_1Hz), .clk_2kHz(clk_2kHz),
    .start(start), .pause_tgl(pause_tgl), .stop(stop), .phase(phase_b), .secs(secs_b),
    .round(round_b), .paused(paused_b), .done(done_b), .buzzer(buzzer_b));

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hz_per = 100;

  // Model: a session is a list of segments; state is the segment index plus
  // elapsed seconds within it. seg = -1 is IDLE, seg = nseg is DONE.
  typedef struct { int ph; int rnd; int len; } seg_t;
  typedef struct { int seg; int el; int paused; int beep; int buz; } ms_t;
  seg_t sched [2][16];
  int   nseg  [2];
  ms_t  m     [2];
  int   hist  [5];

  typedef struct {
    bit st; bit pt; bit sp; int n;
    int ph; int secs; int rnd; int paused; int done; int buz;
  } vec_t;
  vec_t tbl [23];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int m_phase(input int i);
    if (m[i].seg < 0) return 0;
    if (m[i].seg >= nseg[i]) return 4;
    return sched[i][m[i].seg].ph;
  endfunction

  function automatic int m_secs(input int i);
    if (m[i].seg < 0 || m[i].seg >= nseg[i]) return 0;
    return sched[i][m[i].seg].len - m[i].el;
  endfunction

  function automatic int m_round(input int i);
    if (m[i].seg < 0) return 0;
    if (m[i].seg >= nseg[i]) return M_ROUNDS;
    return sched[i][m[i].seg].rnd;
  endfunction

  task automatic build_sched();
    for (int i = 0; i < 2; i++) begin
      int prep = (i == 0) ? 1 : 0;
      int n = 0;
      if (prep > 0) begin sched[i][n] = '{1, 1, prep}; n++; end
      for (int r = 1; r <= M_ROUNDS; r++) begin
        sched[i][n] = '{2, r, M_WORK}; n++;
        if (r < M_ROUNDS) begin sched[i][n] = '{3, r, M_REST}; n++; end
      end
      nseg[i] = n;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) m[i] = '{-1, 0, 0, 0, 0};
    for (int k = 0; k < 5; k++) hist[k] = 0;
  endtask

  task automatic model_edge(input bit st, input bit pt, input bit sp, input bit c2k, input bit tk);
    for (int i = 0; i < 2; i++) begin
      ms_t s = m[i];
      bit active = (s.seg >= 0) && (s.seg < nseg[i]);
      int nb = s.beep;
      int nbuz = (c2k && s.beep > 0) ? 1 : 0;
      if (tk && nb > 0) nb--;
      if (sp) begin
        s.seg = -1; s.el = 0; s.paused = 0; nb = 0; nbuz = 0;
      end else if (st && !active) begin
        s.seg = 0; s.el = 0; s.paused = 0; nb = M_BEEP;
      end else if (pt && active) begin
        s.paused = 1 - s.paused;
      end else if (tk && active && s.paused == 0) begin
        s.el++;
        if (s.el == sched[i][s.seg].len) begin
          s.seg++;
          s.el = 0;
          nb = (s.seg == nseg[i]) ? 3 * M_BEEP : M_BEEP;
        end
      end
      s.beep = nb;
      s.buz  = nbuz;
      m[i]   = s;
    end
  endtask

  task automatic cmp_all();
    chk("a.phase",  phase_a,  m_phase(0));
    chk("a.secs",   secs_a,   m_secs(0));
    chk("a.round",  round_a,  m_round(0));
    chk("a.paused", paused_a, m[0].paused);
    chk("a.done",   done_a,   (m[0].seg == nseg[0]) ? 1 : 0);
    chk("a.buzzer", buzzer_a, m[0].buz);
    chk("b.phase",  phase_b,  m_phase(1));
    chk("b.secs",   secs_b,   m_secs(1));
    chk("b.round",  round_b,  m_round(1));
    chk("b.paused", paused_b, m[1].paused);
    chk("b.done",   done_b,   (m[1].seg == nseg[1]) ? 1 : 0);
    chk("b.buzzer", buzzer_b, m[1].buz);
  endtask

  // One clk_in cycle: drive at the negedge, model at the posedge, compare at the next negedge.
  task automatic step(input bit st, input bit pt, input bit sp);
    bit tk;
    start     = st;
    pause_tgl = pt;
    stop      = sp;
    clk_1Hz   = ((cyc % hz_per) >= (hz_per / 2));
    clk_2kHz  = (((cyc / 5) % 2) == 1);
    @(posedge clk_in);
    for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = clk_1Hz ? 1 : 0;
    tk = (hist[3] == 1) && (hist[4] == 0);
    model_edge(st, pt, sp, clk_2kHz, tk);
    cyc++;
    @(negedge clk_in);
    cmp_all();
    start = 1'b0; pause_tgl = 1'b0; stop = 1'b0;
  endtask

  task automatic idle_until(input int off);
    while ((cyc % 100) != off) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".phase"},  phase_a,  0);
    chk({tag, ".secs"},   secs_a,   0);
    chk({tag, ".round"},  round_a,  0);
    chk({tag, ".paused"}, paused_a, 0);
    chk({tag, ".done"},   done_a,   0);
    chk({tag, ".buzzer"}, buzzer_a, 0);
    chk({tag, ".b_phase"}, phase_b, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {start, pause, stop, cycles, phase, secs, round, paused, done, buzzer(-1 = any)}
    tbl[0]  = '{1, 0, 0,  11, 1, 1, 1, 0, 0, -1};
    tbl[1]  = '{0, 0, 0, 100, 2, 3, 1, 0, 0, -1};
    tbl[2]  = '{0, 0, 0, 100, 2, 2, 1, 0, 0, -1};
    tbl[3]  = '{0, 0, 0, 100, 2, 1, 1, 0, 0, -1};
    tbl[4]  = '{0, 0, 0, 100, 3, 2, 1, 0, 0, -1};
    tbl[5]  = '{0, 0, 0, 100, 3, 1, 1, 0, 0, -1};
    tbl[6]  = '{0, 0, 0, 100, 2, 3, 2, 0, 0, -1};
    tbl[7]  = '{0, 0, 0, 100, 2, 2, 2, 0, 0, -1};
    tbl[8]  = '{0, 0, 0, 100, 2, 1, 2, 0, 0, -1};
    tbl[9]  = '{0, 0, 0, 100, 4, 0, 2, 0, 1, -1};
    tbl[10] = '{0, 0, 0, 100, 4, 0, 2, 0, 1, 0};
    tbl[11] = '{1, 0, 0,  11, 1, 1, 1, 0, 0, -1};
    tbl[12] = '{0, 0, 0, 100, 2, 3, 1, 0, 0, -1};
    tbl[13] = '{0, 0, 0, 100, 2, 2, 1, 0, 0, -1};
    tbl[14] = '{0, 1, 0,   3, 2, 2, 1, 1, 0, -1};
    tbl[15] = '{0, 0, 0, 300, 2, 2, 1, 1, 0, 0};
    tbl[16] = '{0, 1, 0,   3, 2, 2, 1, 0, 0, -1};
    tbl[17] = '{0, 0, 0, 100, 2, 1, 1, 0, 0, -1};
    tbl[18] = '{1, 0, 0,   2, 2, 1, 1, 0, 0, -1};
    tbl[19] = '{0, 0, 0, 100, 3, 2, 1, 0, 0, -1};
    tbl[20] = '{0, 0, 1,   1, 0, 0, 0, 0, 0, 0};
    tbl[21] = '{1, 0, 1,   1, 0, 0, 0, 0, 0, 0};
    tbl[22] = '{1, 0, 0,   3, 1, 1, 1, 0, 0, -1};

    build_sched();
    model_reset();

    // Power-on reset
    @(negedge clk_in);
    chk_reset_outputs("por");
    reset_n = 1'b1;

    // Reset asserted mid-session clears outputs without a clock edge
    idle_until(0);
    step(1'b1, 1'b0, 1'b0);
    repeat (149) step(1'b0, 1'b0, 1'b0);
    chk("mid.phase_before_reset", phase_a, 2);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    reset_n = 1'b1;
    repeat (300) step(1'b0, 1'b0, 1'b0);
    chk("post_rst.idle_phase", phase_a, 0);

    // Directed vector table, aligned to the 1 Hz period
    idle_until(0);
    for (int v = 0; v < 23; v++) begin
      step(tbl[v].st, tbl[v].pt, tbl[v].sp);
      for (int k = 1; k < tbl[v].n; k++) step(1'b0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d.phase", v),  phase_a,  tbl[v].ph);
      chk($sformatf("tbl%0d.secs", v),   secs_a,   tbl[v].secs);
      chk($sformatf("tbl%0d.round", v),  round_a,  tbl[v].rnd);
      chk($sformatf("tbl%0d.paused", v), paused_a, tbl[v].paused);
      chk($sformatf("tbl%0d.done", v),   done_a,   tbl[v].done);
      if (tbl[v].buz >= 0) chk($sformatf("tbl%0d.buzzer", v), buzzer_a, tbl[v].buz);
      $display("vector %0d: phase=%0d secs=%0d round=%0d paused=%0d done=%0d",
               v, phase_a, secs_a, round_a, paused_a, done_a);
    end

    // pause_tgl coincident with the tick at secs=1 in WORK
    idle_until(53); step(1'b0, 1'b0, 1'b0);
    chk("coinc.work3", secs_a, 3);
    idle_until(53); step(1'b0, 1'b0, 1'b0);
    idle_until(53); step(1'b0, 1'b0, 1'b0);
    chk("coinc.work1", secs_a, 1);
    idle_until(53); step(1'b0, 1'b1, 1'b0);
    chk("coinc.phase", phase_a, 2);
    chk("coinc.secs", secs_a, 1);
    chk("coinc.paused", paused_a, 1);
    idle_until(53); step(1'b0, 1'b0, 1'b0);
    chk("coinc.held", secs_a, 1);
    step(1'b0, 1'b1, 1'b0);
    idle_until(53); step(1'b0, 1'b0, 1'b0);
    chk("coinc.rest_phase", phase_a, 3);
    chk("coinc.rest_secs", secs_a, 2);
    $display("coincident pause: phase=%0d secs=%0d paused=%0d", phase_a, secs_a, paused_a);

    // PREP_S=0 start and synchroniser latency (edge sampled at drive cyc 50)
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("prep0.phase", phase_b, 2);
    chk("prep0.secs", secs_b, 3);
    chk("prep0.round", round_b, 1);
    idle_until(50);
    step(1'b0, 1'b0, 1'b0); chk("sync.edge1", secs_b, 3);
    step(1'b0, 1'b0, 1'b0); chk("sync.edge2", secs_b, 3);
    step(1'b0, 1'b0, 1'b0); chk("sync.edge3", secs_b, 3);
    step(1'b0, 1'b0, 1'b0); chk("sync.edge4", secs_b, 2);
    $display("sync latency: secs_b=%0d after 4 edges", secs_b);

    // Randomised events against the model
    hz_per = 20;
    for (int t = 0; t < 4000; t++) begin
      int r = $urandom_range(0, 99);
      bit st = (r < 3) || (r == 8) || (r == 9);
      bit pt = (r >= 3 && r < 7) || (r == 9);
      bit sp = (r == 7) || (r == 8);
      step(st, pt, sp);
      if (st || pt || sp)
        $display("rand t=%0d st=%0d pt=%0d sp=%0d -> phase=%0d secs=%0d round=%0d",
                 t, st, pt, sp, phase_a, secs_a, round_a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
